symbol_round_ctrl: RTL and testbench
====================================

// Module: symbol_round_ctrl
// PURPOSE
// Game-round controller. It is the initiator side of the answer-period handshake.
// Per round: picks a target symbol, shows a pseudo-random symbol stream at the 1 Hz
// cadence and counts target hits. It then pulses answerSig and waits for postSig from
// the answer-period block, scores userCount against the true count, and advances.
// PARAMETERS
// SYMS_PER_ROUND  8        symbols shown per round, 1..255
// NUM_ROUNDS      4        rounds per game, 1..15
// POST_TIMEOUT    10       tick1Hz ticks to wait for postSig before forced miss, >=1
// LFSR_SEED       16'hACE1 LFSR reset value, must be nonzero
// PORTS
// Clk100M      in   1  system clock; all logic on posedge
// rstN         in   1  reset, asynchronous, active-low
// tick1Hz      in   1  one-cycle strobe in Clk100M domain, once per second
// start        in   1  begin game; sampled only in IDLE/DONE
// postSig      in   1  one-cycle pulse: answer period finished
// userCount    in   8  player's count; valid in the postSig cycle
// answerSig    out  1  one-cycle pulse: open answer period
// symbolOut    out  2  symbol currently shown
// symbolValid  out  1  symbolOut is live
// targetSym    out  2  symbol the player must count
// trueCount    out  8  target hits shown this round
// score        out  4  correct rounds this game, saturates at 15
// roundNum     out  4  current round, 1-based; 0 before first ARM
// lastCorrect  out  1  result of most recent scored round
// gameOver     out  1  high while in DONE
// BEHAVIOUR
// Reset (rstN=0, immediate): state=IDLE, lfsr=LFSR_SEED, symCnt=0, waitCnt=0.
//   All outputs are 0. No answerSig is ever emitted as a result of reset.
// LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts left, feedback into bit 0.
//   It steps only where a "step" is listed below. sym = lfsr[1:0] before the step.
// IDLE: start -> ARM.
// ARM (1 cycle): targetSym<=sym, step, trueCount<=0, symCnt<=0, roundNum+=1 -> SHOW.
// SHOW, on each tick1Hz:
//   - if symCnt<SYMS_PER_ROUND: symbolOut<=sym, symbolValid<=1, step, symCnt+=1,
//     trueCount+=(sym==targetSym).
//   - else: symbolValid<=0 -> ASK.
//   Net effect: the first symbol appears at the first tick after ARM, and each symbol
//   is shown for exactly one tick period.
// ASK (1 cycle): answerSig=1 (registered, high only in this cycle), waitCnt<=0 -> WAIT.
//   answerSig therefore rises the cycle after the terminating tick.
// WAIT:
//   - postSig: capture userCount -> SCORE (hit=userCount==trueCount).
//   - else tick1Hz: waitCnt+=1; if waitCnt reaches POST_TIMEOUT -> SCORE, hit=0.
//   - postSig and tick1Hz in the same cycle: postSig wins, waitCnt ignored.
// SCORE (1 cycle): lastCorrect<=hit; score+=hit (saturating).
//   roundNum==NUM_ROUNDS -> DONE, else -> ARM.
// DONE: gameOver=1, outputs hold. start -> score<=0, roundNum<=0, lastCorrect<=0 -> ARM.
//   The LFSR is not reseeded on restart.
// Ignored inputs:
//   - postSig outside WAIT is ignored (no state or score change).
//   - start outside IDLE/DONE is ignored.
//   - tick1Hz has no effect outside SHOW and WAIT.
// Widths: trueCount cannot overflow since SYMS_PER_ROUND<=255. Compare is 8-bit exact.
// Reset mid-operation: asynchronous return to IDLE with the reset values above.
//   A pending handshake is abandoned; a later stray postSig is ignored.
// TESTING
// 1 SYMS=4, tick every 10 clk, start:
//   -> 4 symbols each held 10 clk; symbolValid falls on 5th tick;
//   -> answerSig high exactly 1 cycle, next cycle.
// 2 Scoreboard LFSR model vs symbolOut/targetSym/trueCount for 3 rounds
//   -> exact match each symbol.
// 3 In WAIT, postSig with userCount=trueCount
//   -> SCORE next cycle, lastCorrect=1, score 0->1.
// 4 postSig with userCount=trueCount+1 -> lastCorrect=0, score unchanged.
//   Also: postSig during SHOW -> no effect.
// 5 No postSig, POST_TIMEOUT=10
//   -> after 10th tick in WAIT, lastCorrect=0, roundNum+1, new target.
//   Also: postSig and tick in the same cycle -> postSig result used.
// 6 NUM_ROUNDS=2 to end
//   -> gameOver=1, roundNum=2; start -> score=0, roundNum=1.
//   Also: rstN low mid-SHOW -> all outputs 0 same cycle, state IDLE.

Source files
------------

// File: rtl/symbol_round_ctrl_if.sv
// rtl/symbol_round_ctrl_if.sv - answer-period handshake between the round controller and the answer block
interface symbol_round_ctrl_if;
   logic       answerSig;
   logic       postSig;
   logic [7:0] userCount;

   modport master (output answerSig, input postSig, input userCount);
   modport slave  (input answerSig, output postSig, output userCount);
endinterface

// File: rtl/symbol_round_ctrl.sv
// rtl/symbol_round_ctrl.sv - game-round controller: target pick, LFSR symbol stream, answer handshake, scoring
module symbol_round_ctrl #(
   parameter int          SYMS_PER_ROUND = 8,
   parameter int          NUM_ROUNDS     = 4,
   parameter int          POST_TIMEOUT   = 10,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic                       Clk100M,
   input  logic                       rstN,
   input  logic                       tick1Hz,
   input  logic                       start,
   symbol_round_ctrl_if.master        ans,
   output logic [1:0]                 symbolOut,
   output logic                       symbolValid,
   output logic [1:0]                 targetSym,
   output logic [7:0]                 trueCount,
   output logic [3:0]                 score,
   output logic [3:0]                 roundNum,
   output logic                       lastCorrect,
   output logic                       gameOver
);

   localparam int          WW         = $clog2(POST_TIMEOUT + 1);
   localparam logic [7:0]  SYMS_LIM   = 8'(SYMS_PER_ROUND);
   localparam logic [3:0]  ROUNDS_LIM = 4'(NUM_ROUNDS);
   localparam logic [WW-1:0] POST_LIM = WW'(POST_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_SHOW, S_ASK, S_WAIT, S_SCORE, S_DONE
   } state_t;

   state_t        state, stateNext;
   logic [15:0]   lfsr;
   logic [15:0]   lfsrNext;
   logic [1:0]    sym;
   logic [7:0]    symCnt;
   logic [WW-1:0] waitCnt;
   logic [WW-1:0] waitInc;
   logic          hit;
   logic          showDone;
   logic          waitExpired;

   // Fibonacci taps 16,14,13,11; the displayed symbol is taken before the shift.
   assign lfsrNext    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign sym         = lfsr[1:0];
   assign waitInc     = waitCnt + 1'b1;
   assign showDone    = (symCnt >= SYMS_LIM);
   assign waitExpired = tick1Hz && (waitInc == POST_LIM);

   always_ff @(posedge Clk100M or negedge rstN) begin
      if (!rstN) state <= S_IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         S_IDLE:  if (start) stateNext = S_ARM;
         S_ARM:   stateNext = S_SHOW;
         S_SHOW:  if (tick1Hz && showDone) stateNext = S_ASK;
         S_ASK:   stateNext = S_WAIT;
         S_WAIT:  if (ans.postSig || waitExpired) stateNext = S_SCORE;
         S_SCORE: stateNext = (roundNum == ROUNDS_LIM) ? S_DONE : S_ARM;
         S_DONE:  if (start) stateNext = S_ARM;
         default: stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk100M or negedge rstN) begin
      if (!rstN) begin
         lfsr          <= LFSR_SEED;
         symCnt        <= '0;
         waitCnt       <= '0;
         hit           <= 1'b0;
         ans.answerSig <= 1'b0;
         symbolOut     <= '0;
         symbolValid   <= 1'b0;
         targetSym     <= '0;
         trueCount     <= '0;
         score         <= '0;
         roundNum      <= '0;
         lastCorrect   <= 1'b0;
         gameOver      <= 1'b0;
      end else begin
         // Decoding the next state keeps both strobes aligned exactly to their state.
         ans.answerSig <= (stateNext == S_ASK);
         gameOver      <= (stateNext == S_DONE);
         case (state)
            S_ARM: begin
               targetSym <= sym;
               lfsr      <= lfsrNext;
               trueCount <= '0;
               symCnt    <= '0;
               roundNum  <= roundNum + 4'd1;
            end
            S_SHOW: begin
               if (tick1Hz) begin
                  if (!showDone) begin
                     symbolOut   <= sym;
                     symbolValid <= 1'b1;
                     lfsr        <= lfsrNext;
                     symCnt      <= symCnt + 8'd1;
                     if (sym == targetSym) trueCount <= trueCount + 8'd1;
                  end else begin
                     symbolValid <= 1'b0;
                  end
               end
            end
            S_ASK: waitCnt <= '0;
            S_WAIT: begin
               // A postSig arriving with the final tick still counts as an answer.
               if (ans.postSig) begin
                  hit <= (ans.userCount == trueCount);
               end else if (tick1Hz) begin
                  waitCnt <= waitInc;
                  if (waitInc == POST_LIM) hit <= 1'b0;
               end
            end
            S_SCORE: begin
               lastCorrect <= hit;
               if (hit && (score != 4'hF)) score <= score + 4'd1;
            end
            S_DONE: begin
               if (start) begin
                  score       <= '0;
                  roundNum    <= '0;
                  lastCorrect <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_symbol_round_ctrl.sv
// tb/tb_symbol_round_ctrl.sv - directed bench for symbol_round_ctrl with LFSR scoreboard
module tb_symbol_round_ctrl;

   logic       Clk100M;
   logic       rstN;
   logic       tick1Hz;
   logic       start;
   logic [1:0] symbolOut;
   logic       symbolValid;
   logic [1:0] targetSym;
   logic [7:0] trueCount;
   logic [3:0] score;
   logic [3:0] roundNum;
   logic       lastCorrect;
   logic       gameOver;

   symbol_round_ctrl_if ans_if ();

   symbol_round_ctrl #(
      .SYMS_PER_ROUND (4),
      .NUM_ROUNDS     (2),
      .POST_TIMEOUT   (10),
      .LFSR_SEED      (16'hACE1)
   ) dut (
      .Clk100M     (Clk100M),
      .rstN        (rstN),
      .tick1Hz     (tick1Hz),
      .start       (start),
      .ans         (ans_if.master),
      .symbolOut   (symbolOut),
      .symbolValid (symbolValid),
      .targetSym   (targetSym),
      .trueCount   (trueCount),
      .score       (score),
      .roundNum    (roundNum),
      .lastCorrect (lastCorrect),
      .gameOver    (gameOver)
   );

   initial Clk100M = 1'b0;
   always #5 Clk100M = ~Clk100M;

   int          nChecks = 0;
   int          nErrors = 0;
   logic [15:0] ml;
   logic [1:0]  mTarget;
   logic [7:0]  mCount;
   logic [3:0]  mScore;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   task automatic clk1();
      @(posedge Clk100M);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) clk1();
   endtask

   task automatic tick();
      tick1Hz = 1'b1;
      clk1();
      tick1Hz = 1'b0;
   endtask

   task automatic post(input logic [7:0] cnt);
      ans_if.postSig   = 1'b1;
      ans_if.userCount = cnt;
      clk1();
      ans_if.postSig   = 1'b0;
   endtask

   // Called with the DUT in ARM; leaves it in SHOW with the target checked.
   task automatic arm_round(input logic [3:0] expRound);
      clk1();
      check_val("arm_target", {14'd0, targetSym}, {14'd0, ml[1:0]});
      check_val("arm_round", {12'd0, roundNum}, {12'd0, expRound});
      check_val("arm_count0", {8'd0, trueCount}, 16'd0);
      check_val("arm_novalid", {15'd0, symbolValid}, 16'd0);
      mTarget = ml[1:0];
      ml      = lstep(ml);
      mCount  = 8'd0;
   endtask

   // Shows 4 symbols, ends the stream, and leaves the DUT in WAIT.
   task automatic show_round();
      logic [1:0] expSym;
      expSym = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin
            post(mCount);
            idle(8);
            check_val("show_post_ignored", {12'd0, score}, {12'd0, mScore});
            check_val("show_still_valid", {15'd0, symbolValid}, 16'd1);
         end else begin
            idle(9);
         end
         if (i > 0) check_val("sym_hold", {14'd0, symbolOut}, {14'd0, expSym});
         tick();
         expSym = ml[1:0];
         if (expSym == mTarget) mCount++;
         ml = lstep(ml);
         check_val("sym_out", {14'd0, symbolOut}, {14'd0, expSym});
         check_val("sym_valid", {15'd0, symbolValid}, 16'd1);
         check_val("true_count", {8'd0, trueCount}, {8'd0, mCount});
      end
      idle(9);
      tick();
      check_val("end_valid_low", {15'd0, symbolValid}, 16'd0);
      check_val("answer_high", {15'd0, ans_if.answerSig}, 16'd1);
      clk1();
      check_val("answer_one_cycle", {15'd0, ans_if.answerSig}, 16'd0);
   endtask

   initial begin
      rstN             = 1'b0;
      tick1Hz          = 1'b0;
      start            = 1'b0;
      ans_if.postSig   = 1'b0;
      ans_if.userCount = 8'd0;
      ml     = 16'hACE1;
      mScore = 4'd0;
      idle(3);
      check_val("rst_outputs", {symbolOut, symbolValid, targetSym, trueCount, score},
                {2'd0, 1'b0, 2'd0, 8'd0, 3'd0});
      check_val("rst_misc", {12'd0, roundNum[2:0], lastCorrect}, 16'd0);
      check_val("rst_flags", {14'd0, gameOver, ans_if.answerSig}, 16'd0);
      check_val("rst_score_hi", {15'd0, score[3]}, 16'd0);
      rstN = 1'b1;
      idle(2);

      // Game 1, round 1: correct answer.
      start = 1'b1;
      clk1();
      start = 1'b0;
      arm_round(4'd1);
      check_val("first_target", {14'd0, targetSym}, 16'd1);
      show_round();
      post(mCount);
      clk1();
      mScore = 4'd1;
      check_val("r1_last", {15'd0, lastCorrect}, 16'd1);
      check_val("r1_score", {12'd0, score}, 16'd1);

      // Round 2: off-by-one answer, game ends.
      arm_round(4'd2);
      show_round();
      post(mCount + 8'd1);
      clk1();
      check_val("r2_last", {15'd0, lastCorrect}, 16'd0);
      check_val("r2_score", {12'd0, score}, 16'd1);
      check_val("r2_gameover", {15'd0, gameOver}, 16'd1);
      idle(25);
      tick();
      check_val("done_hold_over", {15'd0, gameOver}, 16'd1);
      check_val("done_hold_round", {12'd0, roundNum}, 16'd2);

      // Restart: score/round clear, LFSR continues.
      start = 1'b1;
      clk1();
      start = 1'b0;
      mScore = 4'd0;
      check_val("restart_score", {12'd0, score}, 16'd0);
      check_val("restart_over", {15'd0, gameOver}, 16'd0);
      arm_round(4'd1);
      show_round();

      // No answer: timeout exactly at the 10th tick in WAIT.
      for (int i = 0; i < 9; i++) begin
         idle(9);
         tick();
      end
      idle(9);
      check_val("to_not_yet", {12'd0, roundNum}, 16'd1);
      tick();
      clk1();
      check_val("to_last", {15'd0, lastCorrect}, 16'd0);
      check_val("to_score", {12'd0, score}, 16'd0);
      arm_round(4'd2);
      show_round();

      // postSig lands with the 10th tick: the answer must win.
      for (int i = 0; i < 9; i++) begin
         idle(9);
         tick();
      end
      idle(9);
      tick1Hz = 1'b1;
      post(mCount);
      tick1Hz = 1'b0;
      clk1();
      check_val("coinc_last", {15'd0, lastCorrect}, 16'd1);
      check_val("coinc_score", {12'd0, score}, 16'd1);
      check_val("coinc_over", {15'd0, gameOver}, 16'd1);

      // Reset in the middle of SHOW.
      start = 1'b1;
      clk1();
      start = 1'b0;
      clk1();
      idle(9);
      tick();
      idle(4);
      #2;
      rstN = 1'b0;
      #1;
      check_val("mrst_outputs", {symbolOut, symbolValid, targetSym, trueCount, score},
                {2'd0, 1'b0, 2'd0, 8'd0, 3'd0});
      check_val("mrst_round", {11'd0, roundNum, lastCorrect}, 16'd0);
      check_val("mrst_flags", {14'd0, gameOver, ans_if.answerSig}, 16'd0);
      clk1();
      rstN = 1'b1;
      ml   = 16'hACE1;
      post(8'd0);
      idle(9);
      tick();
      idle(3);
      check_val("idle_stray_post", {13'd0, score[2:0]}, 16'd0);
      check_val("idle_no_answer", {14'd0, ans_if.answerSig, symbolValid}, 16'd0);
      check_val("idle_round", {12'd0, roundNum}, 16'd0);
      start = 1'b1;
      clk1();
      start = 1'b0;
      arm_round(4'd1);
      check_val("reseed_target", {14'd0, targetSym}, 16'd1);
      idle(9);
      tick();
      check_val("reseed_sym", {14'd0, symbolOut}, 16'd3);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
